// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one single-port synchronous-read data RAM between
//               instruction fetch (IF) and load/store (LS). LS has fixed
//               priority. A starvation counter forces one IF grant after
//               MAX_WAIT consecutive denied IF cycles. Read data returns one
//               cycle after the grant, and a per-owner rvalid pulse marks it.
// Ports       :
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             IF read request and word address
//   if_gnt                     IF accepted this cycle (combinational)
//   if_rvalid/if_rdata         IF completion (registered) and data (= ram_dout)
//   ls_req/ls_we/ls_addr/
//   ls_wdata                   LS request, write flag, address, write data
//   ls_gnt                     LS accepted this cycle (combinational)
//   ls_rvalid/ls_rdata         LS completion (registered) and data (= ram_dout)
//   ram_we/ram_addr/ram_din    RAM command
//   ram_dout                   RAM registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    typedef enum logic [0:0] {
        LS_PRIO = 1'b0,
        IF_PRIO = 1'b1
    } prio_e;

    prio_e       prio_q,      prio_d;
    logic [3:0]  wait_cnt_q,  wait_cnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_rvalid_q, ls_rvalid_d;

    // Grant decode. Gated by rst_n so nothing is granted (and no write
    // reaches the RAM) while reset is held.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (rst_n) begin
            if (if_req && ls_req) begin
                if (prio_q == IF_PRIO) begin
                    if_gnt = 1'b1;
                end else begin
                    ls_gnt = 1'b1;
                end
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    // RAM command follows the winning requester; idle drives address 0.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = ls_wdata;
        if (if_gnt) begin
            ram_addr = if_addr;
        end else if (ls_gnt) begin
            ram_addr = ls_addr;
            ram_we   = ls_we;
        end
    end

    // Starvation counter and priority state. The state looks at the next
    // counter value so IF is forced on the very cycle after the MAX_WAIT-th
    // denial, not one cycle later.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        prio_d      = prio_q;
        if_rvalid_d = if_gnt;
        ls_rvalid_d = ls_gnt;

        if (!if_req || if_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < c_max_wait) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        unique case (prio_q)
            LS_PRIO: begin
                if (wait_cnt_d == c_max_wait) begin
                    prio_d = IF_PRIO;
                end
            end
            IF_PRIO: begin
                if (if_gnt || !if_req) begin
                    prio_d = LS_PRIO;
                end
            end
            default: prio_d = LS_PRIO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= LS_PRIO;
            wait_cnt_q  <= 4'd0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            wait_cnt_q  <= wait_cnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = ram_dout;
    assign ls_rdata  = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed bench for ram_port_arbiter with a behavioural
//               64x32 synchronous-read RAM and a side preload port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] mem [64];

    int n_pass;
    int n_total;

    ram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: read-before-write on the same edge, preload port
    // used only while the arbiter is in reset.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        @(negedge clk); pre_we = 1'b1; pre_addr = 6'd1; pre_data = 32'h1111_1111;
        @(negedge clk); pre_addr = 6'd2; pre_data = 32'h2222_2222;
        @(negedge clk); pre_addr = 6'd5; pre_data = 32'hDEAD_BEEF;
        @(negedge clk); pre_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 6'd7; ls_wdata = 32'hCAFE_0007;
        #1;
        n_total++; if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) $display("FAIL reset_gnt: got if=%b ls=%b want 0 0", if_gnt, ls_gnt); else n_pass++;
        n_total++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", ram_we); else n_pass++;
        @(negedge clk);
        n_total++; if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) $display("FAIL reset_rvalid: got if=%b ls=%b want 0 0", if_rvalid, ls_rvalid); else n_pass++;
        ls_we = 1'b0; rst_n = 1'b1;
        #1;
        n_total++; if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) $display("FAIL release_ls_first: got if=%b ls=%b want 0 1", if_gnt, ls_gnt); else n_pass++;
        @(negedge clk); if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_if_alone();
        @(negedge clk); if_req = 1'b1; if_addr = 6'd5; ls_req = 1'b0;
        #1;
        n_total++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || ram_addr !== 6'd5 || ram_we !== 1'b0)
            $display("FAIL if_alone_gnt: got gnt=%b/%b addr=%0d we=%b want 1/0 5 0", if_gnt, ls_gnt, ram_addr, ram_we); else n_pass++;
        @(negedge clk);
        n_total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) $display("FAIL if_alone_data: got v=%b d=%h want 1 deadbeef", if_rvalid, if_rdata); else n_pass++;
        n_total++; if (ls_rvalid !== 1'b0) $display("FAIL if_alone_ls_rvalid: got %b want 0", ls_rvalid); else n_pass++;
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ls_write_read();
        @(negedge clk); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 6'd10; ls_wdata = 32'h1234_5678;
        #1;
        n_total++; if (ls_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 6'd10 || ram_din !== 32'h1234_5678)
            $display("FAIL ls_write_cmd: got gnt=%b we=%b addr=%0d din=%h want 1 1 10 12345678", ls_gnt, ram_we, ram_addr, ram_din); else n_pass++;
        @(negedge clk);
        n_total++; if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0) $display("FAIL ls_write_rvalid: got ls=%b if=%b want 1 0", ls_rvalid, if_rvalid); else n_pass++;
        ls_we = 1'b0;
        #1;
        n_total++; if (ls_gnt !== 1'b1 || ram_we !== 1'b0) $display("FAIL ls_read_cmd: got gnt=%b we=%b want 1 0", ls_gnt, ram_we); else n_pass++;
        @(negedge clk);
        n_total++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h1234_5678) $display("FAIL ls_read_data: got v=%b d=%h want 1 12345678", ls_rvalid, ls_rdata); else n_pass++;
        ls_req = 1'b0;
        @(negedge clk);
        n_total++; if (ls_rvalid !== 1'b0) $display("FAIL ls_rvalid_single: got %b want 0", ls_rvalid); else n_pass++;
    endtask

    task automatic test_contention();
        logic exp_if;
        logic prev_if;
        prev_if = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_total++; if (if_rvalid !== prev_if || ls_rvalid !== !prev_if)
                    $display("FAIL contention_rvalid c%0d: got if=%b ls=%b want %b %b", c, if_rvalid, ls_rvalid, prev_if, !prev_if); else n_pass++;
                n_total++; if (prev_if ? (if_rdata !== 32'h1111_1111) : (ls_rdata !== 32'h2222_2222))
                    $display("FAIL contention_data c%0d: got if=%h ls=%h", c, if_rdata, ls_rdata); else n_pass++;
            end
            if (c == 0) begin
                if_req = 1'b1; if_addr = 6'd1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 6'd2;
            end
            #1;
            exp_if = ((c % 5) == 4);
            n_total++; if (if_gnt !== exp_if || ls_gnt !== !exp_if)
                $display("FAIL contention_gnt c%0d: got if=%b ls=%b want %b %b", c, if_gnt, ls_gnt, exp_if, !exp_if); else n_pass++;
            prev_if = exp_if;
        end
        @(negedge clk); if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [4];
        logic [DATA_W-1:0] datas [4];
        logic              is_if [4];
        addrs[0] = 6'd1; datas[0] = 32'h1111_1111; is_if[0] = 1'b1;
        addrs[1] = 6'd2; datas[1] = 32'h2222_2222; is_if[1] = 1'b0;
        addrs[2] = 6'd5; datas[2] = 32'hDEAD_BEEF; is_if[2] = 1'b1;
        addrs[3] = 6'd2; datas[3] = 32'h2222_2222; is_if[3] = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_total++; if (if_rvalid !== is_if[i-1] || ls_rvalid !== !is_if[i-1])
                    $display("FAIL b2b_rvalid %0d: got if=%b ls=%b want %b %b", i-1, if_rvalid, ls_rvalid, is_if[i-1], !is_if[i-1]); else n_pass++;
                n_total++; if (is_if[i-1] ? (if_rdata !== datas[i-1]) : (ls_rdata !== datas[i-1]))
                    $display("FAIL b2b_data %0d: got if=%h ls=%h want %h", i-1, if_rdata, ls_rdata, datas[i-1]); else n_pass++;
            end
            if (i < 4) begin
                if_req = is_if[i]; ls_req = !is_if[i]; ls_we = 1'b0;
                if_addr = addrs[i]; ls_addr = addrs[i];
            end else begin
                if_req = 1'b0; ls_req = 1'b0;
            end
        end
        @(negedge clk);
        n_total++; if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) $display("FAIL b2b_no_extra: got if=%b ls=%b want 0 0", if_rvalid, ls_rvalid); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic exp_if;
        // Reset lands while an IF rvalid is outstanding and an LS write waits.
        @(negedge clk); if_req = 1'b1; if_addr = 6'd5; ls_req = 1'b0;
        #1;
        n_total++; if (if_gnt !== 1'b1) $display("FAIL mid_if_gnt: got %b want 1", if_gnt); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 6'd5; ls_wdata = 32'hBAD0_BAD0;
        #1;
        n_total++; if (if_rvalid !== 1'b0) $display("FAIL mid_rvalid_cleared: got %b want 0", if_rvalid); else n_pass++;
        n_total++; if (ram_we !== 1'b0 || ls_gnt !== 1'b0) $display("FAIL mid_no_write: got we=%b gnt=%b want 0 0", ram_we, ls_gnt); else n_pass++;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1; ls_req = 1'b0; ls_we = 1'b0; if_req = 1'b1; if_addr = 6'd5;
        @(negedge clk);
        n_total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) $display("FAIL mid_ram_intact: got v=%b d=%h want 1 deadbeef", if_rvalid, if_rdata); else n_pass++;
        if_req = 1'b0;
        @(negedge clk);
        // Reset while IF_PRIO is pending with a saturated counter.
        if_req = 1'b1; if_addr = 6'd1; ls_req = 1'b1; ls_addr = 6'd2;
        for (int c = 0; c < 4; c++) @(negedge clk);
        #1;
        n_total++; if (if_gnt !== 1'b1) $display("FAIL starve_forced: got %b want 1", if_gnt); else n_pass++;
        #1 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_if = (c == 4);
            n_total++; if (if_gnt !== exp_if || ls_gnt !== !exp_if)
                $display("FAIL post_reset_prio c%0d: got if=%b ls=%b want %b %b", c, if_gnt, ls_gnt, exp_if, !exp_if); else n_pass++;
        end
        @(negedge clk); if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_if_alone();
        test_ls_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
